pair_event_counter: RTL and testbench

//  Sequential stage placed directly downstream of the pair/triple detector.

---
 rtl/pair_event_counter_if.sv | 29 ++
 rtl/pair_event_counter.sv | 92 +++++++++
 tb/tb_pair_event_counter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/pair_event_counter_if.sv
// rtl/pair_event_counter_if.sv - sample/clear inputs and status outputs of pair_event_counter
interface pair_event_counter_if #(
    parameter int CNT_W = 8
) ();
    logic             in_val;
    logic             det_in;
    logic             clear;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] streak;
    logic             alarm;

    modport master (
        output in_val,
        output det_in,
        output clear,
        input  count,
        input  streak,
        input  alarm
    );

    modport slave (
        input  in_val,
        input  det_in,
        input  clear,
        output count,
        output streak,
        output alarm
    );
endinterface

// File: rtl/pair_event_counter.sv
// rtl/pair_event_counter.sv - counts detector rising edges, tracks run length, raises alarm
module pair_event_counter #(
    parameter int CNT_W     = 8,
    parameter int ALARM_LEN = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    pair_event_counter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        ALARM = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ALARM_LEN_C = CNT_W'(ALARM_LEN);
    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] streak_q, streak_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + ONE;
    endfunction

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        streak_d = streak_q;

        if (bus.clear) begin
            state_d  = IDLE;
            count_d  = '0;
            streak_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_val && bus.det_in) begin
                        // Only an entry from IDLE is a new detection event.
                        count_d  = sat_inc(count_q);
                        streak_d = ONE;
                        state_d  = (ALARM_LEN == 1) ? ALARM : RUN;
                    end else if (bus.in_val) begin
                        streak_d = '0;
                    end
                end
                RUN: begin
                    if (bus.in_val && bus.det_in) begin
                        streak_d = sat_inc(streak_q);
                        state_d  = (streak_d >= ALARM_LEN_C) ? ALARM : RUN;
                    end else if (bus.in_val) begin
                        streak_d = '0;
                        state_d  = IDLE;
                    end
                end
                ALARM: begin
                    if (bus.in_val && bus.det_in) begin
                        streak_d = sat_inc(streak_q);
                    end else if (bus.in_val) begin
                        streak_d = '0;
                        state_d  = IDLE;
                    end
                end
                default: begin
                    // Unused encoding: drop back to a clean idle on the next edge.
                    state_d  = IDLE;
                    streak_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            streak_q <= streak_d;
        end
    end

    assign bus.count  = count_q;
    assign bus.streak = streak_q;
    assign bus.alarm  = (state_q == ALARM);

endmodule

// File: tb/tb_pair_event_counter.sv
// tb/tb_pair_event_counter.sv - directed table-driven bench for pair_event_counter
module tb_pair_event_counter;

    localparam int CNT_W     = 4;
    localparam int ALARM_LEN = 3;

    logic clk;
    logic reset;

    pair_event_counter_if #(.CNT_W(CNT_W)) bus ();

    pair_event_counter #(
        .CNT_W     (CNT_W),
        .ALARM_LEN (ALARM_LEN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic clr;
        logic val;
        logic det;
        int   cnt;
        int   stk;
        int   alm;
    } vec_t;

    vec_t vecs[$];
    int   n_pass;
    int   n_total;

    function automatic vec_t mk(input logic clr, input logic val, input logic det,
                                input int cnt, input int stk, input int alm);
        vec_t v;
        v.clr = clr; v.val = val; v.det = det;
        v.cnt = cnt; v.stk = stk; v.alm = alm;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_all(input string name, input int cnt, input int stk, input int alm);
        check({name, ".count"},  int'(bus.count),  cnt);
        check({name, ".streak"}, int'(bus.streak), stk);
        check({name, ".alarm"},  int'(bus.alarm),  alm);
    endtask

    task automatic step(input logic clr, input logic val, input logic det);
        @(negedge clk);
        bus.clear  = clr;
        bus.in_val = val;
        bus.det_in = det;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_cnt;
        n_pass  = 0;
        n_total = 0;
        reset      = 1'b0;
        bus.clear  = 1'b0;
        bus.in_val = 1'b0;
        bus.det_in = 1'b0;

        // Test 1: 1,1,0,1
        vecs.push_back(mk(0, 1, 1, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1, 2, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 2, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0));
        // Test 2: 1,1,1,1,0
        vecs.push_back(mk(0, 1, 1, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1, 2, 0));
        vecs.push_back(mk(0, 1, 1, 1, 3, 1));
        vecs.push_back(mk(0, 1, 1, 1, 4, 1));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0));
        // Test 3: gap with in_val=0 and det toggling does not break the run
        vecs.push_back(mk(0, 1, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1, 2, 0));
        vecs.push_back(mk(0, 1, 1, 1, 3, 1));
        // Test 5: clear wins over a valid det=1 sample
        vecs.push_back(mk(1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 0));

        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].clr, vecs[i].val, vecs[i].det);
            check_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].stk, vecs[i].alm);
        end

        // Test 4: 20 repetitions of 1,0 -> count saturates at 15
        step(1, 0, 0);
        exp_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (exp_cnt < 15) exp_cnt++;
            step(0, 1, 1);
            check_all($sformatf("sat_hi%0d", i), exp_cnt, 1, 0);
            step(0, 1, 0);
            check_all($sformatf("sat_lo%0d", i), exp_cnt, 0, 0);
        end

        // Streak saturation: alarm stays up once streak pins at 15
        step(1, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            step(0, 1, 1);
            if (i >= 14) check_all($sformatf("streak_sat%0d", i), 1, (i > 15) ? 15 : i, 1);
        end

        // Test 6: asynchronous reset mid-ALARM
        step(1, 0, 0);
        step(0, 1, 1);
        step(0, 1, 1);
        step(0, 1, 1);
        check_all("pre_reset", 1, 3, 1);
        bus.in_val = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_all("async_reset", 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        step(0, 1, 1);
        check_all("post_reset", 1, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
